// File: rtl/line_cmd_sched.sv
// Line command scheduler: two round-robin requesters feed a command FIFO, and an issue FSM drives the engine one line at a time.
// Optional watchdog on the RUN state is built when LINE_SCHED_TIMEOUT_EN is defined.
module line_cmd_sched #(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 600000
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [4*COORD_W-1:0]     req0_cmd,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [4*COORD_W-1:0]     req1_cmd,
  output logic                     req1_ready,
  input  logic                     eng_done,
  output logic                     eng_go,
  output logic [COORD_W-1:0]       eng_stax,
  output logic [COORD_W-1:0]       eng_stay,
  output logic [COORD_W-1:0]       eng_endx,
  output logic [COORD_W-1:0]       eng_endy,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         lines_done,
  output logic                     err_timeout
);

  localparam int unsigned CMD_W  = 4 * COORD_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CMD_W-1:0]    mem_q [DEPTH];
  logic [CMD_W-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   count_q, count_d;
  logic                last_grant_q, last_grant_d;
  logic [CMD_W-1:0]    eng_pos_q, eng_pos_d;
  logic                eng_go_q, eng_go_d;
  logic [CNT_W-1:0]    lines_done_q, lines_done_d;
  logic                full, push, pop, wd_expire;
  logic [CMD_W-1:0]    push_cmd;

  // Round-robin arbiter: on a tie the requester that did not win last time gets the slot.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!full) begin
      req0_ready = req0_valid & (~req1_valid | last_grant_q);
      req1_ready = req1_valid & (~req0_valid | ~last_grant_q);
    end
  end

  assign full         = (count_q == FCNT_W'(DEPTH));
  assign push         = req0_ready | req1_ready;
  assign push_cmd     = req0_ready ? req0_cmd : req1_cmd;
  assign last_grant_d = push ? req1_ready : last_grant_q;
  assign pop          = (state_q == S_IDLE) && (count_q != '0);

  // Circular FIFO, no bypass path from push to pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_cmd;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + FCNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - FCNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RUN;
      S_RUN:   if (eng_done || wd_expire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: load endpoints on pop, go while leaving ISSUE, count completions.
  always_comb begin
    eng_pos_d    = eng_pos_q;
    eng_go_d     = 1'b0;
    lines_done_d = lines_done_q;
    case (state_q)
      S_IDLE:  if (pop) eng_pos_d = mem_q[rd_ptr_q];
      S_ISSUE: eng_go_d = 1'b1;
      S_RUN:   if (eng_done) lines_done_d = lines_done_q + CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      eng_pos_q    <= '0;
      eng_go_q     <= 1'b0;
      lines_done_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      eng_pos_q    <= eng_pos_d;
      eng_go_q     <= eng_go_d;
      lines_done_q <= lines_done_d;
    end
  end

  // Storage only; validity is tracked by the pointers and count.
  always_ff @(posedge pclk) begin
    mem_q <= mem_d;
  end

`ifdef LINE_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // Watchdog: cleared in ISSUE, counts RUN cycles; a done on the expiry edge takes priority.
  always_comb begin
    wd_d      = wd_q;
    err_d     = err_q;
    wd_expire = 1'b0;
    if (state_q == S_ISSUE) begin
      wd_d = '0;
    end else if (state_q == S_RUN) begin
      wd_d = wd_q + WD_W'(1);
      if (!eng_done && (wd_q == WD_W'(TIMEOUT_CYC - 1))) begin
        wd_expire = 1'b1;
        err_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^32'(TIMEOUT_CYC);
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign eng_go     = eng_go_q;
  assign eng_stax   = eng_pos_q[4*COORD_W-1 -: COORD_W];
  assign eng_stay   = eng_pos_q[3*COORD_W-1 -: COORD_W];
  assign eng_endx   = eng_pos_q[2*COORD_W-1 -: COORD_W];
  assign eng_endy   = eng_pos_q[COORD_W-1 -: COORD_W];
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign lines_done = lines_done_q;

endmodule
